// File: rtl/frog_pkg.sv
`default_nettype none
// frog_pkg -- shared facing/state types, screen constants and a step helper (rev 1.0).
// Used by frog_move_ctrl and frog_btn_latch; the FROG_DRIFT_EN build option lives in the top.
package frog_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } facing_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HOP     = 2'b01,
    DEAD    = 2'b10,
    RESPAWN = 2'b11
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int TILE_PX  = 32;

  // Moves pos one step toward tgt; positions stay step-aligned so this lands exactly.
  function automatic logic [9:0] step_toward(
    input logic [9:0] pos,
    input logic [9:0] tgt,
    input logic [9:0] step
  );
    logic [9:0] res;
    res = pos;
    if (pos < tgt) begin
      res = pos + step;
    end else if (pos > tgt) begin
      res = pos - step;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frog_btn_latch.sv
`default_nettype none
// frog_btn_latch -- button rising-edge detect, up>down>left>right priority, one-entry request (rev 1.0).
module frog_btn_latch
  import frog_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    btn_up,
  input  logic    btn_down,
  input  logic    btn_left,
  input  logic    btn_right,
  input  logic    clear,
  input  logic    block,
  output logic    req_valid,
  output facing_t req_dir
);

  logic [3:0] r_prev;
  logic [3:0] w_level;
  logic [3:0] w_rise;
  facing_t    w_dir;

  assign w_level = {btn_up, btn_down, btn_left, btn_right};
  assign w_rise  = w_level & ~r_prev;

  always_comb begin
    w_dir = RIGHT;
    if (w_rise[3]) begin
      w_dir = UP;
    end else if (w_rise[2]) begin
      w_dir = DOWN;
    end else if (w_rise[1]) begin
      w_dir = LEFT;
    end
  end

  // A fresh edge beats a same-cycle consume, so a press on the serving tick is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= 4'b0000;
      req_valid <= 1'b0;
      req_dir   <= UP;
    end else begin
      r_prev <= w_level;
      if (block) begin
        req_valid <= 1'b0;
      end else if (|w_rise) begin
        req_valid <= 1'b1;
        req_dir   <= w_dir;
      end else if (clear) begin
        req_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frog_move_ctrl.sv
`default_nettype none
// frog_move_ctrl -- frame-paced tile hops, death hold and respawn for the frog sprite (rev 1.0).
// Define FROG_DRIFT_EN to add the drift_dx input (log/turtle carry while idle).
module frog_move_ctrl
  import frog_pkg::*;
#(
  parameter int TILE        = TILE_PX,
  parameter int HOP_STEP    = 4,
  parameter int MIN_X       = 0,
  parameter int MAX_X       = 608,
  parameter int MIN_Y       = 32,
  parameter int MAX_Y       = 448,
  parameter int START_X     = 304,
  parameter int START_Y     = 448,
  parameter int DEAD_FRAMES = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              kill,
`ifdef FROG_DRIFT_EN
  input  logic signed [3:0] drift_dx,
`endif
  output logic [9:0]        frog_x,
  output logic [9:0]        frog_y,
  output logic [9:0]        frog_size,
  output logic [1:0]        facing,
  output logic              hopping,
  output logic              dead,
  output logic              hop_pulse,
  output logic              home_pulse
);

  localparam int STEPS = TILE / HOP_STEP;
  localparam int CW    = $clog2(STEPS) + 1;
  localparam int FW    = $clog2(DEAD_FRAMES) + 1;

  localparam logic [9:0]    C_TILE     = 10'(TILE);
  localparam logic [9:0]    C_STEP     = 10'(HOP_STEP);
  localparam logic [CW-1:0] LAST_STEP  = CW'(STEPS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(DEAD_FRAMES - 1);

  state_t        r_state;
  logic [9:0]    r_tgt_x;
  logic [9:0]    r_tgt_y;
  logic [CW-1:0] r_step_cnt;
  logic [FW-1:0] r_frame_cnt;

  logic          w_req_valid;
  facing_t       w_req_dir;
  logic          w_kill_take;
  logic          w_consume;
  logic          w_block;
  logic          w_move_ok;
  logic [9:0]    w_tgt_x;
  logic [9:0]    w_tgt_y;
  logic [CW-1:0] w_step_next;

  assign frog_size   = C_TILE;
  assign w_kill_take = kill && (r_state != DEAD);
  assign w_consume   = (r_state == IDLE) && frame_tick && w_req_valid && !w_kill_take;
  assign w_block     = (r_state == DEAD);
  assign w_step_next = r_step_cnt + CW'(1);

  frog_btn_latch u_btn_latch (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .clear     (w_consume),
    .block     (w_block),
    .req_valid (w_req_valid),
    .req_dir   (w_req_dir)
  );

  // Bounds are tested before any subtraction so the 10-bit target never wraps.
  always_comb begin
    w_move_ok = 1'b0;
    w_tgt_x   = frog_x;
    w_tgt_y   = frog_y;
    case (w_req_dir)
      UP: begin
        if (frog_y >= 10'(MIN_Y + TILE)) begin
          w_move_ok = 1'b1;
          w_tgt_y   = frog_y - C_TILE;
        end
      end
      DOWN: begin
        if ((11'(frog_y) + 11'(TILE)) <= 11'(MAX_Y)) begin
          w_move_ok = 1'b1;
          w_tgt_y   = frog_y + C_TILE;
        end
      end
      LEFT: begin
        if (frog_x >= 10'(MIN_X + TILE)) begin
          w_move_ok = 1'b1;
          w_tgt_x   = frog_x - C_TILE;
        end
      end
      default: begin
        if ((11'(frog_x) + 11'(TILE)) <= 11'(MAX_X)) begin
          w_move_ok = 1'b1;
          w_tgt_x   = frog_x + C_TILE;
        end
      end
    endcase
  end

`ifdef FROG_DRIFT_EN
  logic signed [10:0] w_drift_sum;
  logic               w_drift_out;

  always_comb begin
    w_drift_sum = $signed({1'b0, frog_x}) + $signed({{7{drift_dx[3]}}, drift_dx});
    w_drift_out = (w_drift_sum < $signed(11'(MIN_X))) || (w_drift_sum > $signed(11'(MAX_X)));
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      frog_x      <= 10'(START_X);
      frog_y      <= 10'(START_Y);
      facing      <= UP;
      r_tgt_x     <= 10'(START_X);
      r_tgt_y     <= 10'(START_Y);
      r_step_cnt  <= '0;
      r_frame_cnt <= '0;
      hopping     <= 1'b0;
      dead        <= 1'b0;
      hop_pulse   <= 1'b0;
      home_pulse  <= 1'b0;
    end else begin
      hop_pulse  <= 1'b0;
      home_pulse <= 1'b0;
      if (w_kill_take) begin
        // Kill overrides any tick in the same clk, including the landing of a hop.
        r_state     <= DEAD;
        dead        <= 1'b1;
        hopping     <= 1'b0;
        r_frame_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (frame_tick) begin
              if (w_req_valid) begin
                facing    <= w_req_dir;
                hop_pulse <= 1'b1;
                if (w_move_ok) begin
                  // The accepting tick already takes the first step of the hop.
                  r_tgt_x    <= w_tgt_x;
                  r_tgt_y    <= w_tgt_y;
                  frog_x     <= step_toward(frog_x, w_tgt_x, C_STEP);
                  frog_y     <= step_toward(frog_y, w_tgt_y, C_STEP);
                  r_step_cnt <= '0;
                  r_state    <= HOP;
                  hopping    <= 1'b1;
                end
              end
`ifdef FROG_DRIFT_EN
              else if (w_drift_out) begin
                r_state     <= DEAD;
                dead        <= 1'b1;
                r_frame_cnt <= '0;
              end else begin
                frog_x <= w_drift_sum[9:0];
              end
`endif
            end
          end
          HOP: begin
            if (frame_tick) begin
              r_step_cnt <= w_step_next;
              if (w_step_next == LAST_STEP) begin
                frog_x     <= r_tgt_x;
                frog_y     <= r_tgt_y;
                r_state    <= IDLE;
                hopping    <= 1'b0;
                home_pulse <= (r_tgt_y == 10'(MIN_Y));
              end else begin
                frog_x <= step_toward(frog_x, r_tgt_x, C_STEP);
                frog_y <= step_toward(frog_y, r_tgt_y, C_STEP);
              end
            end
          end
          DEAD: begin
            if (frame_tick) begin
              if (r_frame_cnt == LAST_FRAME) begin
                r_state <= RESPAWN;
                dead    <= 1'b0;
              end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
              end
            end
          end
          RESPAWN: begin
            frog_x  <= 10'(START_X);
            frog_y  <= 10'(START_Y);
            facing  <= UP;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frog_move_ctrl.sv
`default_nettype none
// tb_frog_move_ctrl -- directed stimulus checked every clk against a frame-level frog model.
module tb_frog_move_ctrl;

  localparam int TILE        = 32;
  localparam int HOP_STEP    = 4;
  localparam int MIN_X       = 0;
  localparam int MAX_X       = 608;
  localparam int MIN_Y       = 32;
  localparam int MAX_Y       = 448;
  localparam int START_X     = 304;
  localparam int START_Y     = 448;
  localparam int DEAD_FRAMES = 60;
  localparam int STEPS       = TILE / HOP_STEP;

  localparam int M_IDLE = 0;
  localparam int M_HOP  = 1;
  localparam int M_DEAD = 2;
  localparam int M_RESP = 3;

  localparam int D_UP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic kill = 1'b0;
`ifdef FROG_DRIFT_EN
  logic signed [3:0] drift_dx = 4'sd0;
`endif
  logic [9:0] frog_x, frog_y, frog_size;
  logic [1:0] facing;
  logic       hopping, dead, hop_pulse, home_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  frog_move_ctrl dut (
    .clk        (clk),
    .reset      (rst),
    .frame_tick (frame_tick),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .kill       (kill),
`ifdef FROG_DRIFT_EN
    .drift_dx   (drift_dx),
`endif
    .frog_x     (frog_x),
    .frog_y     (frog_y),
    .frog_size  (frog_size),
    .facing     (facing),
    .hopping    (hopping),
    .dead       (dead),
    .hop_pulse  (hop_pulse),
    .home_pulse (home_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: position in plain integers, hop as a signed per-frame velocity.
  int         m_x, m_y, m_mode, m_moved, m_dead_n, m_sx, m_sy;
  logic [1:0] m_face, m_pdir;
  bit         m_pend, m_hp, m_home;
  logic [3:0] m_prev;

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] lv, rise;
    bit         was_pend, consumed;
    logic [1:0] was_dir;
    int         was_mode, dx, dy, tx, ty;
    if (rst) begin
      m_x = START_X; m_y = START_Y; m_face = 2'd0; m_mode = M_IDLE;
      m_moved = 0; m_dead_n = 0; m_sx = 0; m_sy = 0;
      m_pend = 1'b0; m_pdir = 2'd0; m_hp = 1'b0; m_home = 1'b0; m_prev = 4'd0;
    end else begin
      m_hp = 1'b0; m_home = 1'b0; consumed = 1'b0;
      was_pend = m_pend; was_dir = m_pdir; was_mode = m_mode;
      lv = {btn_up, btn_down, btn_left, btn_right};
      rise = lv & ~m_prev;
      m_prev = lv;
      if (kill && m_mode != M_DEAD) begin
        m_mode = M_DEAD; m_dead_n = 0;
      end else if (frame_tick || m_mode == M_RESP) begin
        case (m_mode)
          M_IDLE: if (was_pend) begin
              consumed = 1'b1; m_face = was_dir; m_hp = 1'b1;
              dx = 0; dy = 0;
              case (was_dir)
                2'd0: dy = -TILE;
                2'd1: dy = TILE;
                2'd2: dx = -TILE;
                default: dx = TILE;
              endcase
              tx = m_x + dx; ty = m_y + dy;
              if (tx >= MIN_X && tx <= MAX_X && ty >= MIN_Y && ty <= MAX_Y) begin
                m_sx = (dx / TILE) * HOP_STEP; m_sy = (dy / TILE) * HOP_STEP;
                m_x += m_sx; m_y += m_sy; m_moved = 1; m_mode = M_HOP;
              end
            end
`ifdef FROG_DRIFT_EN
            else begin
              tx = m_x + int'(drift_dx);
              if (tx < MIN_X || tx > MAX_X) begin
                m_mode = M_DEAD; m_dead_n = 0;
              end else begin
                m_x = tx;
              end
            end
`endif
          M_HOP: begin
            m_x += m_sx; m_y += m_sy; m_moved++;
            if (m_moved == STEPS) begin
              m_mode = M_IDLE;
              if (m_y == MIN_Y) m_home = 1'b1;
            end
          end
          M_DEAD: begin
            m_dead_n++;
            if (m_dead_n == DEAD_FRAMES) m_mode = M_RESP;
          end
          default: begin
            m_x = START_X; m_y = START_Y; m_face = 2'd0; m_mode = M_IDLE;
          end
        endcase
      end
      if (was_mode == M_DEAD) begin
        m_pend = 1'b0;
      end else if (rise != 4'd0) begin
        m_pend = 1'b1;
        m_pdir = rise[3] ? 2'd0 : rise[2] ? 2'd1 : rise[1] ? 2'd2 : 2'd3;
      end else if (consumed) begin
        m_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("frog_x", frog_x, m_x);
      check("frog_y", frog_y, m_y);
      check("frog_size", frog_size, TILE);
      check("facing", facing, m_face);
      check("hopping", hopping, (m_mode == M_HOP) ? 1 : 0);
      check("dead", dead, (m_mode == M_DEAD) ? 1 : 0);
      check("hop_pulse", hop_pulse, m_hp);
      check("home_pulse", home_pulse, m_home);
    end
  end

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic press(input int d);
    @(negedge clk);
    case (d)
      D_UP:    btn_up = 1'b1;
      D_DOWN:  btn_down = 1'b1;
      D_LEFT:  btn_left = 1'b1;
      default: btn_right = 1'b1;
    endcase
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
  endtask

  task automatic hop(input int d);
    press(d);
    repeat (STEPS) tick();
  endtask

  task automatic pulse_kill();
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: time limit reached before the end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_x", frog_x, 304);
    check("rst_y", frog_y, 448);
    check("rst_facing", facing, 0);
    check("rst_hopping", hopping, 0);
    check("rst_dead", dead, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Bottom row: down is illegal, facing still turns.
    press(D_DOWN); tick();
    check("down_blocked_facing", facing, 1);
    check("down_blocked_y", frog_y, 448);
    check("down_blocked_hop_pulse", hop_pulse, 1);
    check("down_blocked_hopping", hopping, 0);

    // Up hop: first step on the accepting tick, landing on tick 8.
    press(D_UP); tick();
    check("up_t1_hop_pulse", hop_pulse, 1);
    check("up_t1_y", frog_y, 444);
    check("up_t1_facing", facing, 0);
    repeat (6) tick();
    check("up_t7_y", frog_y, 420);
    check("up_t7_hopping", hopping, 1);
    tick();
    check("up_t8_y", frog_y, 416);
    check("up_t8_hopping", hopping, 0);

    // Simultaneous left+right picks left; right pressed mid-hop is served afterwards.
    @(negedge clk); btn_left = 1'b1; btn_right = 1'b1;
    @(negedge clk); btn_left = 1'b0; btn_right = 1'b0;
    tick();
    check("lr_facing", facing, 2);
    check("lr_x", frog_x, 300);
    tick();
    press(D_RIGHT);
    repeat (6) tick();
    check("lr_land_x", frog_x, 272);
    check("lr_land_facing", facing, 2);
    tick();
    check("queued_right_facing", facing, 3);
    check("queued_right_pulse", hop_pulse, 1);
    check("queued_right_x", frog_x, 276);
    repeat (7) tick();
    check("queued_right_land_x", frog_x, 304);

    // Walk to the left edge, then a left press only turns the frog.
    repeat (9) hop(D_LEFT);
    check("left_edge_x", frog_x, 16);
    hop(D_UP);
    check("left_edge_y", frog_y, 384);
    press(D_LEFT); tick();
    check("left_blocked_facing", facing, 2);
    check("left_blocked_x", frog_x, 16);
    check("left_blocked_hopping", hopping, 0);

    // Climb to the home row.
    repeat (10) hop(D_UP);
    check("pre_home_y", frog_y, 64);
    press(D_UP);
    repeat (7) tick();
    check("home_pulse_early", home_pulse, 0);
    tick();
    check("home_y", frog_y, 32);
    check("home_pulse", home_pulse, 1);
    @(negedge clk);
    check("home_pulse_one_clk", home_pulse, 0);

    // Kill at hop step 3 freezes the frog; a second kill and a press while dead do nothing.
    press(D_DOWN);
    repeat (3) tick();
    check("mid_hop_y", frog_y, 44);
    pulse_kill();
    check("kill_dead", dead, 1);
    check("kill_frozen_y", frog_y, 44);
    check("kill_hopping", hopping, 0);
    press(D_UP);
    pulse_kill();
    repeat (DEAD_FRAMES - 1) tick();
    check("dead_59", dead, 1);
    check("dead_59_y", frog_y, 44);
    tick();
    check("dead_60", dead, 0);
    @(negedge clk);
    check("respawn_x", frog_x, 304);
    check("respawn_y", frog_y, 448);
    check("respawn_facing", facing, 0);
    tick();
    check("dead_press_ignored", hop_pulse, 0);

    // Kill on the landing tick wins over the landing.
    press(D_UP);
    repeat (STEPS - 1) tick();
    @(negedge clk); frame_tick = 1'b1; kill = 1'b1;
    @(negedge clk); frame_tick = 1'b0; kill = 1'b0;
    check("kill_last_dead", dead, 1);
    check("kill_last_y", frog_y, 420);
    check("kill_last_home", home_pulse, 0);
    repeat (DEAD_FRAMES) tick();
    @(negedge clk);

    // Asynchronous reset mid-hop acts without waiting for a clock edge.
    press(D_UP);
    repeat (3) tick();
    check("pre_reset_y", frog_y, 436);
    #2 rst = 1'b1;
    #1;
    check("async_rst_y", frog_y, 448);
    check("async_rst_x", frog_x, 304);
    check("async_rst_hopping", hopping, 0);
    @(negedge clk); rst = 1'b0;
    tick();
    check("post_reset_no_hop", hopping, 0);

`ifdef FROG_DRIFT_EN
    drift_dx = 4'sd3;
    repeat (100) tick();
    check("drift_x_604", frog_x, 604);
    drift_dx = 4'sd2;
    tick();
    check("drift_x_606", frog_x, 606);
    drift_dx = 4'sd3;
    tick();
    check("drift_off_edge_dead", dead, 1);
    check("drift_off_edge_x", frog_x, 606);
    drift_dx = 4'sd0;
    repeat (4) tick();
`endif

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
